// File: rtl/axil_reg4_slave.sv
// Four 32-bit AXI4-Lite registers; update on the edge entering W_RESP, BVALID/RVALID one cycle after the last handshake.
// Backpressure: AW/W are refused until the B response is taken, AR is refused until the R beat is taken.
module axil_reg4_slave #(
   parameter int C_S_AXI_DATA_WIDTH = 32,
   parameter int C_S_AXI_ADDR_WIDTH = 6
) (
   input  logic                          ACLK,
   input  logic                          ARESET,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_AWADDR,
   input  logic [2:0]                    S_AXI_AWPROT,
   input  logic                          S_AXI_AWVALID,
   output logic                          S_AXI_AWREADY,
   input  logic [C_S_AXI_DATA_WIDTH-1:0] S_AXI_WDATA,
   input  logic [3:0]                    S_AXI_WSTRB,
   input  logic                          S_AXI_WVALID,
   output logic                          S_AXI_WREADY,
   output logic [1:0]                    S_AXI_BRESP,
   output logic                          S_AXI_BVALID,
   input  logic                          S_AXI_BREADY,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_ARADDR,
   input  logic [2:0]                    S_AXI_ARPROT,
   input  logic                          S_AXI_ARVALID,
   output logic                          S_AXI_ARREADY,
   output logic [C_S_AXI_DATA_WIDTH-1:0] S_AXI_RDATA,
   output logic [1:0]                    S_AXI_RRESP,
   output logic                          S_AXI_RVALID,
   input  logic                          S_AXI_RREADY,
   output logic [C_S_AXI_DATA_WIDTH-1:0] reg0_o,
   output logic [C_S_AXI_DATA_WIDTH-1:0] reg1_o,
   output logic [C_S_AXI_DATA_WIDTH-1:0] reg2_o,
   output logic [C_S_AXI_DATA_WIDTH-1:0] reg3_o,
   output logic [3:0]                    wr_pulse_o
);

   localparam int DW = C_S_AXI_DATA_WIDTH;
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [1:0] {W_IDLE, W_GOT_ADDR, W_GOT_DATA, W_RESP} w_state_e;
   typedef enum logic {R_IDLE, R_DATA} r_state_e;

   w_state_e          w_state_q, w_state_d;
   r_state_e          r_state_q, r_state_d;
   logic [DW-1:0]     regs_q [4];
   logic [1:0]        aw_idx_q;
   logic              aw_oor_q;
   logic [DW-1:0]     w_data_q;
   logic [3:0]        w_strb_q;
   logic [1:0]        bresp_q;
   logic [DW-1:0]     rdata_q;
   logic [1:0]        rresp_q;
   logic [3:0]        wr_pulse_q;

   logic              aw_hs, w_hs, ar_hs;
   logic              aw_oor, ar_oor;
   logic              wr_fire;
   logic [1:0]        wr_idx;
   logic              wr_oor;
   logic [DW-1:0]     wr_data;
   logic [3:0]        wr_strb;
   logic              unused_ok;

   // Anything with a bit set at or above bit 4 lies outside the register window.
   assign aw_oor = (S_AXI_AWADDR >> 4) != '0;
   assign ar_oor = (S_AXI_ARADDR >> 4) != '0;

   assign S_AXI_AWREADY = !ARESET && (w_state_q == W_IDLE || w_state_q == W_GOT_DATA);
   assign S_AXI_WREADY  = !ARESET && (w_state_q == W_IDLE || w_state_q == W_GOT_ADDR);
   assign S_AXI_ARREADY = !ARESET && (r_state_q == R_IDLE);

   assign aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
   assign w_hs  = S_AXI_WVALID  && S_AXI_WREADY;
   assign ar_hs = S_AXI_ARVALID && S_AXI_ARREADY;

   always_comb begin
      w_state_d = w_state_q;
      wr_fire   = 1'b0;
      wr_idx    = aw_idx_q;
      wr_oor    = aw_oor_q;
      wr_data   = w_data_q;
      wr_strb   = w_strb_q;
      case (w_state_q)
         W_IDLE: begin
            if (aw_hs && w_hs) begin
               w_state_d = W_RESP;
               wr_fire   = 1'b1;
               wr_idx    = S_AXI_AWADDR[3:2];
               wr_oor    = aw_oor;
               wr_data   = S_AXI_WDATA;
               wr_strb   = S_AXI_WSTRB;
            end else if (aw_hs) begin
               w_state_d = W_GOT_ADDR;
            end else if (w_hs) begin
               w_state_d = W_GOT_DATA;
            end
         end
         W_GOT_ADDR: begin
            if (w_hs) begin
               w_state_d = W_RESP;
               wr_fire   = 1'b1;
               wr_data   = S_AXI_WDATA;
               wr_strb   = S_AXI_WSTRB;
            end
         end
         W_GOT_DATA: begin
            if (aw_hs) begin
               w_state_d = W_RESP;
               wr_fire   = 1'b1;
               wr_idx    = S_AXI_AWADDR[3:2];
               wr_oor    = aw_oor;
            end
         end
         W_RESP: begin
            if (S_AXI_BREADY) begin
               w_state_d = W_IDLE;
            end
         end
         default: w_state_d = W_IDLE;
      endcase
   end

   always_comb begin
      r_state_d = r_state_q;
      case (r_state_q)
         R_IDLE:  if (ar_hs) r_state_d = R_DATA;
         R_DATA:  if (S_AXI_RREADY) r_state_d = R_IDLE;
         default: r_state_d = R_IDLE;
      endcase
   end

   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         w_state_q  <= W_IDLE;
         aw_idx_q   <= '0;
         aw_oor_q   <= 1'b0;
         w_data_q   <= '0;
         w_strb_q   <= '0;
         bresp_q    <= RESP_OKAY;
         wr_pulse_q <= '0;
         for (int i = 0; i < 4; i++) regs_q[i] <= '0;
      end else begin
         w_state_q  <= w_state_d;
         wr_pulse_q <= '0;
         if (aw_hs) begin
            aw_idx_q <= S_AXI_AWADDR[3:2];
            aw_oor_q <= aw_oor;
         end
         if (w_hs) begin
            w_data_q <= S_AXI_WDATA;
            w_strb_q <= S_AXI_WSTRB;
         end
         if (wr_fire) begin
            bresp_q <= wr_oor ? RESP_SLVERR : RESP_OKAY;
            if (!wr_oor && (wr_strb != '0)) begin
               wr_pulse_q[wr_idx] <= 1'b1;
               for (int b = 0; b < 4; b++) begin
                  if (wr_strb[b]) regs_q[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
               end
            end
         end
      end
   end

   // Reads sample regs_q before any same-edge write lands, so they see the old value.
   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         r_state_q <= R_IDLE;
         rdata_q   <= '0;
         rresp_q   <= RESP_OKAY;
      end else begin
         r_state_q <= r_state_d;
         if (ar_hs) begin
            rdata_q <= ar_oor ? '0 : regs_q[S_AXI_ARADDR[3:2]];
            rresp_q <= ar_oor ? RESP_SLVERR : RESP_OKAY;
         end
      end
   end

   assign S_AXI_BVALID = (w_state_q == W_RESP);
   assign S_AXI_BRESP  = bresp_q;
   assign S_AXI_RVALID = (r_state_q == R_DATA);
   assign S_AXI_RDATA  = rdata_q;
   assign S_AXI_RRESP  = rresp_q;
   assign reg0_o       = regs_q[0];
   assign reg1_o       = regs_q[1];
   assign reg2_o       = regs_q[2];
   assign reg3_o       = regs_q[3];
   assign wr_pulse_o   = wr_pulse_q;

   assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

endmodule

// File: tb/tb_axil_reg4_slave.sv
// Directed bench for axil_reg4_slave: scoreboard queues of expected B/R beats, reference register model.
module tb_axil_reg4_slave;
   localparam int AW = 6;

   logic          ACLK = 1'b0;
   logic          ARESET;
   logic [AW-1:0] S_AXI_AWADDR;
   logic [2:0]    S_AXI_AWPROT;
   logic          S_AXI_AWVALID;
   logic          S_AXI_AWREADY;
   logic [31:0]   S_AXI_WDATA;
   logic [3:0]    S_AXI_WSTRB;
   logic          S_AXI_WVALID;
   logic          S_AXI_WREADY;
   logic [1:0]    S_AXI_BRESP;
   logic          S_AXI_BVALID;
   logic          S_AXI_BREADY;
   logic [AW-1:0] S_AXI_ARADDR;
   logic [2:0]    S_AXI_ARPROT;
   logic          S_AXI_ARVALID;
   logic          S_AXI_ARREADY;
   logic [31:0]   S_AXI_RDATA;
   logic [1:0]    S_AXI_RRESP;
   logic          S_AXI_RVALID;
   logic          S_AXI_RREADY;
   logic [31:0]   reg0_o, reg1_o, reg2_o, reg3_o;
   logic [3:0]    wr_pulse_o;

   axil_reg4_slave #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(AW)) dut (
      .ACLK(ACLK), .ARESET(ARESET),
      .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT),
      .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
      .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
      .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
      .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
      .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARPROT(S_AXI_ARPROT),
      .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
      .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
      .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
      .reg0_o(reg0_o), .reg1_o(reg1_o), .reg2_o(reg2_o), .reg3_o(reg3_o),
      .wr_pulse_o(wr_pulse_o)
   );

   always #5 ACLK = ~ACLK;

   typedef struct packed { logic [1:0] resp; logic [3:0] pulse; } bexp_t;
   typedef struct packed { logic [31:0] data; logic [1:0] resp; } rexp_t;

   bexp_t       bq[$];
   rexp_t       rq[$];
   logic [31:0] mdl [4];
   int          pulse_cnt [4];
   int          multi_hot = 0;
   int          checks = 0;
   int          errors = 0;

   initial for (int i = 0; i < 4; i++) pulse_cnt[i] = 0;

   always @(negedge ACLK) begin
      for (int i = 0; i < 4; i++) pulse_cnt[i] += int'(wr_pulse_o[i]);
      if ($countones(wr_pulse_o) > 1) multi_hot++;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic timeout(input string tag);
      checks++;
      errors++;
      $error("FAIL %s: observed timeout expected completion", tag);
   endtask

   task automatic tick();
      @(posedge ACLK);
      #1;
   endtask

   task automatic send_aw(input logic [AW-1:0] addr, input int dly);
      bit done = 1'b0;
      repeat (dly) tick();
      S_AXI_AWADDR  = addr;
      S_AXI_AWPROT  = 3'($urandom);
      S_AXI_AWVALID = 1'b1;
      for (int n = 0; n < 50 && !done; n++) begin
         @(negedge ACLK);
         done = S_AXI_AWREADY;
         tick();
      end
      S_AXI_AWVALID = 1'b0;
      if (!done) timeout("aw_handshake");
   endtask

   task automatic send_w(input logic [31:0] data, input logic [3:0] strb, input int dly);
      bit done = 1'b0;
      repeat (dly) tick();
      S_AXI_WDATA  = data;
      S_AXI_WSTRB  = strb;
      S_AXI_WVALID = 1'b1;
      for (int n = 0; n < 50 && !done; n++) begin
         @(negedge ACLK);
         done = S_AXI_WREADY;
         tick();
      end
      S_AXI_WVALID = 1'b0;
      if (!done) timeout("w_handshake");
   endtask

   task automatic wait_b(input int hold);
      bexp_t e;
      int    lat = 0;
      bit    got = 1'b0;
      for (int n = 0; n < 50 && !got; n++) begin
         @(negedge ACLK);
         if (S_AXI_BVALID) got = 1'b1; else lat++;
      end
      if (!got) begin
         timeout("bvalid");
         void'(bq.pop_front());
         return;
      end
      e = bq.pop_front();
      chk("bresp", 32'(S_AXI_BRESP), 32'(e.resp));
      chk("wr_pulse", 32'(wr_pulse_o), 32'(e.pulse));
      chk("b_latency", 32'(lat), 32'd0);
      for (int h = 0; h < hold; h++) begin
         @(negedge ACLK);
         chk("bvalid_hold", 32'(S_AXI_BVALID), 32'd1);
         chk("bresp_hold", 32'(S_AXI_BRESP), 32'(e.resp));
         chk("awready_in_resp", 32'(S_AXI_AWREADY), 32'd0);
         chk("wready_in_resp", 32'(S_AXI_WREADY), 32'd0);
      end
      S_AXI_BREADY = 1'b1;
      tick();
      S_AXI_BREADY = 1'b0;
      chk("bvalid_drop", 32'(S_AXI_BVALID), 32'd0);
   endtask

   task automatic write(input logic [AW-1:0] addr, input logic [31:0] data, input logic [3:0] strb,
                        input int aw_dly, input int w_dly, input int hold);
      bexp_t e;
      bit    oor = (addr >> 4) != '0;
      int    idx = int'(addr[3:2]);
      e.resp  = oor ? 2'b10 : 2'b00;
      e.pulse = (!oor && strb != 4'b0) ? 4'(1 << idx) : 4'b0;
      if (!oor) for (int b = 0; b < 4; b++) if (strb[b]) mdl[idx][8*b +: 8] = data[8*b +: 8];
      bq.push_back(e);
      fork
         send_aw(addr, aw_dly);
         send_w(data, strb, w_dly);
      join
      wait_b(hold);
   endtask

   task automatic read(input logic [AW-1:0] addr, input logic [31:0] exp_data, input int hold);
      rexp_t e;
      bit    got = 1'b0;
      int    lat = 0;
      bit    done = 1'b0;
      e.data = exp_data;
      e.resp = ((addr >> 4) != '0) ? 2'b10 : 2'b00;
      rq.push_back(e);
      S_AXI_ARADDR  = addr;
      S_AXI_ARPROT  = 3'($urandom);
      S_AXI_ARVALID = 1'b1;
      for (int n = 0; n < 50 && !done; n++) begin
         @(negedge ACLK);
         done = S_AXI_ARREADY;
         tick();
      end
      S_AXI_ARVALID = 1'b0;
      if (!done) timeout("ar_handshake");
      for (int n = 0; n < 50 && !got; n++) begin
         @(negedge ACLK);
         if (S_AXI_RVALID) got = 1'b1; else lat++;
      end
      if (!got) begin
         timeout("rvalid");
         void'(rq.pop_front());
         return;
      end
      e = rq.pop_front();
      chk("rdata", S_AXI_RDATA, e.data);
      chk("rresp", 32'(S_AXI_RRESP), 32'(e.resp));
      chk("r_latency", 32'(lat), 32'd0);
      for (int h = 0; h < hold; h++) begin
         @(negedge ACLK);
         chk("rvalid_hold", 32'(S_AXI_RVALID), 32'd1);
         chk("rdata_hold", S_AXI_RDATA, e.data);
         chk("rresp_hold", 32'(S_AXI_RRESP), 32'(e.resp));
         chk("arready_in_data", 32'(S_AXI_ARREADY), 32'd0);
      end
      S_AXI_RREADY = 1'b1;
      tick();
      S_AXI_RREADY = 1'b0;
      chk("rvalid_drop", 32'(S_AXI_RVALID), 32'd0);
   endtask

   task automatic chk_regs(input string tag);
      chk({tag, "_reg0"}, reg0_o, mdl[0]);
      chk({tag, "_reg1"}, reg1_o, mdl[1]);
      chk({tag, "_reg2"}, reg2_o, mdl[2]);
      chk({tag, "_reg3"}, reg3_o, mdl[3]);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_awready"}, 32'(S_AXI_AWREADY), 32'd0);
      chk({tag, "_wready"}, 32'(S_AXI_WREADY), 32'd0);
      chk({tag, "_arready"}, 32'(S_AXI_ARREADY), 32'd0);
      chk({tag, "_bvalid"}, 32'(S_AXI_BVALID), 32'd0);
      chk({tag, "_rvalid"}, 32'(S_AXI_RVALID), 32'd0);
      chk({tag, "_bresp"}, 32'(S_AXI_BRESP), 32'd0);
      chk({tag, "_rresp"}, 32'(S_AXI_RRESP), 32'd0);
      chk({tag, "_rdata"}, S_AXI_RDATA, 32'd0);
      chk({tag, "_wr_pulse"}, 32'(wr_pulse_o), 32'd0);
      chk_regs(tag);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: observed simulation still running expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [31:0] old;
      int          snap;
      bexp_t       e0;

      ARESET = 1'b1;
      S_AXI_AWADDR = '0; S_AXI_AWPROT = '0; S_AXI_AWVALID = 1'b0;
      S_AXI_WDATA = '0;  S_AXI_WSTRB = '0;  S_AXI_WVALID = 1'b0;
      S_AXI_BREADY = 1'b0;
      S_AXI_ARADDR = '0; S_AXI_ARPROT = '0; S_AXI_ARVALID = 1'b0;
      S_AXI_RREADY = 1'b0;
      for (int i = 0; i < 4; i++) mdl[i] = '0;

      // Reset state, then a write presented across deassertion must land on the first edge.
      repeat (3) @(posedge ACLK);
      @(negedge ACLK);
      chk_all_zero("reset");
      S_AXI_AWADDR = 6'h00; S_AXI_AWVALID = 1'b1;
      S_AXI_WDATA = 32'd1;  S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1;
      mdl[0] = 32'd1;
      e0.resp = 2'b00; e0.pulse = 4'b0001;
      bq.push_back(e0);
      #1 ARESET = 1'b0;
      tick();
      S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
      wait_b(0);

      // Simultaneous AW+W to every register, then read back.
      write(6'h04, 32'd2, 4'hF, 0, 0, 0);
      write(6'h08, 32'd3, 4'hF, 0, 0, 0);
      write(6'h0C, 32'd4, 4'hF, 0, 0, 0);
      for (int i = 0; i < 4; i++) read(AW'(4 * i), 32'(i + 1), 0);

      // W ahead of AW, then AW ahead of W.
      snap = pulse_cnt[2];
      write(6'h08, 32'hDEADBEEF, 4'hF, 3, 0, 0);
      chk("reg2_w_first", reg2_o, 32'hDEADBEEF);
      write(6'h08, 32'h0BADF00D, 4'hF, 0, 3, 0);
      chk("reg2_aw_first", reg2_o, 32'h0BADF00D);
      chk("reg2_pulse_cycles", 32'(pulse_cnt[2] - snap), 32'd2);
      read(6'h08, mdl[2], 0);

      // Byte-lane strobes.
      write(6'h04, 32'h11223344, 4'hF, 0, 0, 0);
      write(6'h04, 32'hAABBCCDD, 4'b0101, 1, 0, 0);
      chk("reg1_strobed", reg1_o, 32'h11BB33DD);
      read(6'h04, 32'h11BB33DD, 0);

      // Out-of-range and zero-strobe writes leave every register alone.
      snap = pulse_cnt[0] + pulse_cnt[1] + pulse_cnt[2] + pulse_cnt[3];
      write(6'h10, 32'hFFFFFFFF, 4'hF, 0, 0, 0);
      write(6'h3C, 32'hFFFFFFFF, 4'hF, 0, 2, 0);
      write(6'h0C, 32'hFFFFFFFF, 4'h0, 0, 0, 0);
      chk_regs("no_change");
      chk("no_pulse", 32'(pulse_cnt[0] + pulse_cnt[1] + pulse_cnt[2] + pulse_cnt[3] - snap), 32'd0);
      read(6'h10, 32'd0, 0);
      read(6'h20, 32'd0, 0);

      // Low address bits ignored.
      write(6'h0B, 32'h00000055, 4'b0001, 0, 0, 0);
      chk("reg2_low_bits", reg2_o, 32'h0BADF055);
      read(6'h0A, mdl[2], 0);

      // Backpressure on B and R.
      write(6'h00, 32'h12345678, 4'hF, 0, 0, 5);
      read(6'h00, mdl[0], 5);

      // Read and write of the same register sharing an edge.
      old = mdl[3];
      fork
         write(6'h0C, 32'h0FACE0FF, 4'hF, 0, 0, 0);
         read(6'h0C, old, 0);
      join
      read(6'h0C, 32'h0FACE0FF, 0);

      // Reset while holding only an address.
      write(6'h00, 32'd5, 4'hF, 0, 0, 0);
      chk("reg0_five", reg0_o, 32'd5);
      send_aw(6'h04, 0);
      #2 ARESET = 1'b1;
      for (int i = 0; i < 4; i++) mdl[i] = '0;
      #1 chk_all_zero("async_reset");
      @(negedge ACLK);
      ARESET = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge ACLK);
         chk("no_b_after_reset", 32'(S_AXI_BVALID), 32'd0);
      end
      tick();
      read(6'h00, 32'd0, 0);

      chk("wr_pulse_onehot", 32'(multi_hot), 32'd0);
      chk("scoreboard_empty", 32'(bq.size() + rq.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
